boot_loader: RTL

BOOT_LOADER -- requirements
Module: boot_loader

---
 rtl/boot_loader_pkg.sv | 18 +
 rtl/boot_loader.sv | 129 ++++++++++++
 2 files changed

// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the boot loader.
package boot_loader_pkg;

  typedef enum logic [2:0] {
    S_ADDR_LO = 3'd0,
    S_ADDR_HI = 3'd1,
    S_LEN_LO  = 3'd2,
    S_LEN_HI  = 3'd3,
    S_DATA    = 3'd4,
    S_CSUM    = 3'd5,
    S_DONE    = 3'd6,
    S_ERR     = 3'd7
  } state_t;

  // ADDR_LO, ADDR_HI, LEN_LO, LEN_HI; header states are encoded 0..HDR_BYTES-1
  localparam int HDR_BYTES = 4;

endpackage

// File: rtl/boot_loader.sv
// Byte-stream boot loader: parses an addr/len header, writes payload to RAM, releases the CPU.
// Define BOOT_LOADER_CHECKSUM_EN to require a trailing mod-256 payload checksum byte.
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int HOLD_AFTER_ERR = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [7:0]        RxData,
  input  logic              RxValid,
  output logic              RxReady,
  output logic              MemWE,
  output logic [ADDR_W-1:0] MemAddress,
  output logic [7:0]        MemDataOut,
  output logic              CpuHold,
  output logic              Done,
  output logic              Error
);

`ifdef BOOT_LOADER_CHECKSUM_EN
  localparam state_t S_FINAL = S_CSUM;
`else
  localparam state_t S_FINAL = S_DONE;
`endif

  state_t            state, state_nxt;
  logic [7:0]        addr_lo, len_lo;
  logic [15:0]       remaining;
  logic [ADDR_W-1:0] wr_ptr;
  logic              in_hdr, accept;

  assign in_hdr  = int'(state) < HDR_BYTES;
  assign RxReady = !RST && (in_hdr || state == S_DATA || state == S_CSUM);
  assign accept  = RxValid && RxReady;

`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [7:0] csum;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_ADDR_LO;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (accept) begin
      case (state)
        S_ADDR_LO: state_nxt = S_ADDR_HI;
        S_ADDR_HI: state_nxt = S_LEN_LO;
        S_LEN_LO:  state_nxt = S_LEN_HI;
        S_LEN_HI:  state_nxt = ({RxData, len_lo} != 16'd0) ? S_DATA : S_FINAL;
        S_DATA:    if (remaining == 16'd1) state_nxt = S_FINAL;
`ifdef BOOT_LOADER_CHECKSUM_EN
        S_CSUM:    state_nxt = (csum == RxData) ? S_DONE : S_ERR;
`endif
        default:   state_nxt = state;
      endcase
    end
  end

  // Header capture, write pointer and payload countdown
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      addr_lo   <= '0;
      len_lo    <= '0;
      remaining <= '0;
      wr_ptr    <= '0;
    end else if (accept) begin
      case (state)
        S_ADDR_LO: addr_lo <= RxData;
        S_ADDR_HI: wr_ptr  <= ADDR_W'({RxData, addr_lo});
        S_LEN_LO:  len_lo  <= RxData;
        S_LEN_HI:  remaining <= {RxData, len_lo};
        S_DATA: begin
          remaining <= remaining - 16'd1;
          wr_ptr    <= wr_ptr + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Registered RAM port: one pulse per accepted payload byte, address/data hold when idle
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      MemWE      <= 1'b0;
      MemAddress <= '0;
      MemDataOut <= '0;
    end else begin
      MemWE <= accept && state == S_DATA;
      if (accept && state == S_DATA) begin
        MemAddress <= wr_ptr;
        MemDataOut <= RxData;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      CpuHold <= 1'b1;
      Done    <= 1'b0;
    end else begin
      if (state_nxt == S_DONE && state != S_DONE) begin
        Done    <= 1'b1;
        CpuHold <= 1'b0;
      end
      if (state_nxt == S_ERR && state != S_ERR)
        CpuHold <= (HOLD_AFTER_ERR != 0);
    end
  end

`ifdef BOOT_LOADER_CHECKSUM_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      csum  <= '0;
      Error <= 1'b0;
    end else begin
      if (accept && state == S_DATA) csum <= csum + RxData;
      if (state_nxt == S_ERR && state != S_ERR) Error <= 1'b1;
    end
  end
`else
  assign Error = 1'b0;
`endif

endmodule
